// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared widths, state encodings and handshake constants for div_iter
package div_iter_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration (shift, trial subtract)
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dq,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] next_rem,
  output logic [DATA_W-1:0] next_dq,
  output logic              q_bit
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] diff;

  // rem < divisor always holds, so the top bit of the DATA_W+1 difference is the borrow
  assign partial  = {rem, dq[DATA_W-1]};
  assign diff     = partial - {1'b0, divisor};
  assign q_bit    = ~diff[DATA_W];
  assign next_rem = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
  assign next_dq  = {dq[DATA_W-2:0], q_bit};

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 DIV/DIVU unit; DIV_ZERO_FLAG_EN adds by_zero_o
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                by_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dq;
  logic [DATA_W-1:0] divisor;
  logic              signed_q;
  logic              sign_a;
  logic              sign_b;
`ifdef DIV_ZERO_FLAG_EN
  logic              zero_div;
`endif

  logic [DATA_W-1:0] next_rem;
  logic [DATA_W-1:0] next_dq;
  logic              q_bit;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [DATA_W-1:0] fix_q;
  logic [DATA_W-1:0] fix_r;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem),
    .dq       (dq),
    .divisor  (divisor),
    .next_rem (next_rem),
    .next_dq  (next_dq),
    .q_bit    (q_bit)
  );

  assign abs_a = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign fix_q = (signed_q && (sign_a ^ sign_b)) ? -dq : dq;
  assign fix_r = (signed_q && sign_a) ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      rem      <= '0;
      dq       <= '0;
      divisor  <= '0;
      signed_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
      zero_div  <= 1'b0;
      by_zero_o <= 1'b0;
`endif
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
          by_zero_o <= 1'b0;
`endif
          if (start_i == DivStart && !annul_i) begin
`ifdef DIV_ZERO_FLAG_EN
            zero_div <= (opdata2_i == '0);
`endif
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= '0;
              rem      <= '0;
              dq       <= abs_a;
              divisor  <= abs_b;
              signed_q <= signed_i;
              sign_a   <= opdata1_i[DATA_W-1];
              sign_b   <= opdata2_i[DATA_W-1];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            state    <= DivEnd;
            rem      <= '0;
            dq       <= '0;
            signed_q <= 1'b0;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            rem <= next_rem;
            dq  <= next_dq;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1))
              state <= DivEnd;
          end
        end
        default: begin
          // result is re-registered every cycle while EX keeps start_i asserted
          if (start_i == DivStart) begin
            result_o <= {fix_r, fix_q};
            ready_o  <= DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
            by_zero_o <= zero_div;
`endif
          end else begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            by_zero_o <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider for the MIPS32 core, implementing DIV and DIVU. It sits in the EX stage directly upstream of the HI/LO register file and produces the 64-bit {remainder, quotient} pair that write-back commits as HI (remainder) and LO (quotient). The pipeline stalls while a division is in flight. An annul input discards a division whose instruction is flushed.

## Interface
- DATA_W, 32, operand width; result is 2*DATA_W.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  request; held high by EX until ready_o seen.
- annul_i  in  1  abort current division (branch/exception flush).
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.
- by_zero_o  out  1  divisor was zero (only with DIV_ZERO_FLAG_EN).

## Operation
- States: FREE, BY_ZERO, ON, END. Encodings and ready constants are in the shared define file.
- FREE:
  - start_i=1 and annul_i=0 with opdata2_i==0 -> BY_ZERO.
  - start_i=1 and annul_i=0 with opdata2_i!=0 -> ON.
  - On the transition to ON, the block captures absolute values of the operands (when signed_i=1), the sign flags, and signed_i, and clears the iteration counter. Operand changes after capture are ignored.
- BY_ZERO: next edge -> END, result forced to 0.
- ON: one restoring step per cycle.
  - Shift {rem, dividend} left by one.
  - Trial subtract the divisor (DATA_W+1-bit difference). Keep the result if it is non-negative; the quotient bit is the inverted borrow.
  - Counter runs 0..DATA_W-1. After step DATA_W-1 -> END.
- END:
  - Sign fix-up: quotient negated if the dividend and divisor signs differ; remainder takes the dividend's sign. Applied only when the captured signed flag is 1.
  - result_o and ready_o held while start_i=1. start_i=0 -> FREE, ready_o=0, result_o=0.
- annul_i=1 in BY_ZERO or ON -> FREE next edge; ready_o never asserts for that division. annul_i has no effect in FREE or END.
- start_i deasserted in BY_ZERO or ON is ignored; only annul_i aborts.
- Arithmetic wraps mod 2^32: 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. No trap.

## Timing
- Reset (async, rst=0): state FREE, result_o=0, ready_o=0, by_zero_o=0, counter=0. Outputs clear immediately, not at the next edge.
- Edge E0 samples start_i in FREE.
  - Nonzero divisor: ready_o high after edge E0+33 (32 iterations plus END entry).
  - Zero divisor: ready_o high after edge E0+2.
- All outputs registered; no combinational path from inputs to outputs.
- Back-to-back: start_i must drop for at least one cycle (END -> FREE) before the next request is sampled.
- Reset asserted mid-division aborts it; the block is idle in FREE on the first edge after rst rises.

## Configuration
- DIV_ZERO_FLAG_EN defined:
  - Port by_zero_o exists.
  - Asserted with ready_o for a zero-divisor division, held through END, cleared on FREE or reset.
- Undefined: port absent. Zero-divisor behaviour is otherwise identical: result 0, 2-edge latency.

## Structure
- Shared define file: RegBus, DoubleRegBus, ZeroWord, state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady, DivStart/DivStop.
- One sub-module: div_step. It is combinational: one shift/trial-subtract iteration returning the next {rem, quotient} and the quotient bit. It is instantiated once.

## Test plan
- DIVU 100 / 7 -> result_o = {0x00000002, 0x0000000E}; ready_o exactly 33 edges after start.
- DIV -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 0x1234 / 0 -> result_o = 0, ready_o 2 edges after start; by_zero_o = 1 with DIV_ZERO_FLAG_EN.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at iteration 10 -> FREE next edge, ready_o stays 0; a following DIVU 50 / 5 -> quotient 10, remainder 0 with full 33-edge latency.
- rst driven low between edges during iteration 5 -> ready_o and result_o read 0 before the next edge; after release, a new division completes correctly.
